histogram_bin_arbiter: RTL and testbench
========================================

HISTOGRAM_BIN_ARBITER -- requirements
Module: histogram_bin_arbiter

Interface
REQ-001 Parameters SHALL be: BIN_COUNT, 256, number of histogram bins (power of two); COUNT_WIDTH, 32, bits per bin; ADDR_WIDTH, clog2(BIN_COUNT), derived.
REQ-002 Ports SHALL be:
- clk  in  1  100 MHz primary clock.
- reset  in  1  asynchronous, active-high.
- event_valid  in  1  radiation event offered.
- event_bin  in  ADDR_WIDTH  bin to increment.
- event_ready  out  1  event accepted when valid&ready.
- clear_start  in  1  one-cycle pulse; zero all bins.
- clear_busy  out  1  clear sweep in progress.
- ps_rd_valid  in  1  PS bin read request.
- ps_rd_addr  in  ADDR_WIDTH  bin to read.
- ps_rd_ready  out  1  read accepted when valid&ready.
- ps_rd_data_valid  out  1  one-cycle strobe with result.
- ps_rd_data  out  COUNT_WIDTH  bin value.
- mem_en  out  1  bin RAM enable.
- mem_we  out  1  bin RAM write.
- mem_addr  out  ADDR_WIDTH  bin RAM address.
- mem_wdata  out  COUNT_WIDTH  bin RAM write data.
- mem_rdata  in  COUNT_WIDTH  bin RAM read data, valid 1 cycle after read.
- dropped_count  out  16  events lost (only with HIST_DROP_COUNT_EN).

Function
REQ-003 FSM states SHALL be IDLE, EV_RD, EV_WR, PS_RD, PS_DATA, CLEAR; only one state drives the RAM in any cycle.
REQ-004 In IDLE, clear_start SHALL win; otherwise, if only one of event_valid/ps_rd_valid is high, that requester SHALL be granted; if both, round-robin SHALL apply, with the last grant winner losing the tie.
REQ-005 event_ready and ps_rd_ready SHALL be combinational grant strobes, high only in IDLE for the granted requester; address SHALL be latched on handshake.
REQ-006 Event path: IDLE->EV_RD issues a read (mem_en=1, we=0), EV_RD->EV_WR writes mem_rdata+1, EV_WR->IDLE; throughput one event per 3 cycles.
REQ-007 Increment SHALL saturate at 2^COUNT_WIDTH-1; no wrap.
REQ-008 PS path: IDLE->PS_RD issues a read, PS_RD->PS_DATA, where ps_rd_data=mem_rdata and ps_rd_data_valid=1 for exactly one cycle; PS_DATA->IDLE. Latency from handshake to strobe is 2 cycles.
REQ-009 CLEAR SHALL write 0 to addresses 0..BIN_COUNT-1, one per cycle, ascending, then return to IDLE; clear_busy=1 for exactly BIN_COUNT cycles.
REQ-010 clear_start outside IDLE SHALL be latched as pending and serviced at the next IDLE; an in-flight RMW or PS read completes first.
REQ-011 clear_start during CLEAR SHALL be ignored (no restart).
REQ-012 During CLEAR, event_ready SHALL be 1 and accepted events SHALL be discarded (counted as dropped); ps_rd_ready SHALL be 0.
REQ-013 Events to the same bin back-to-back SHALL each be counted, with no lost increment (no RMW overlap by construction).

Reset
REQ-014 On reset, the FSM SHALL enter IDLE; all outputs SHALL be 0; the round-robin pointer SHALL favour event; pending clear and dropped_count SHALL be 0. RAM contents are not cleared.
REQ-015 Reset mid-RMW or mid-CLEAR SHALL abort immediately; a partially written bin is permitted.

Configuration
REQ-016 Macro HIST_DROP_COUNT_EN: when defined, the dropped_count port exists and increments (saturating at 0xFFFF) per event discarded under REQ-012. When undefined, the port and counter are absent and discards are silent.

Structure
REQ-017 A shared package hist_pkg SHALL hold the FSM state enum, the default BIN_COUNT/COUNT_WIDTH constants and the saturating-increment function.
REQ-018 The round-robin selector SHALL be a sub-module hist_rr_arb (2 requesters, grant + pointer update).

Verification
REQ-019 Single event, bin 5 holding 7 -> read at cycle 1, write 8 to addr 5 at cycle 2, ready again at cycle 3.
REQ-020 Continuous event and PS-read requests -> grants alternate E,P,E,P; PS read of bin 5 returns 8 with a 2-cycle strobe latency.
REQ-021 Bin at 0xFFFFFFFF plus event -> written value stays 0xFFFFFFFF.
REQ-022 clear_start during EV_WR -> write completes, then 256 zero writes; 10 events during the sweep -> dropped_count=10 (macro on); subsequent reads return 0.
REQ-023 Reset asserted at clear address 100 -> outputs 0 next edge, IDLE, clear_busy=0, no pending clear.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared state encoding, default sizing and the saturating-increment helper
// for the histogram bin arbiter.
package hist_pkg;

    localparam int DEF_BIN_COUNT   = 256;
    localparam int DEF_COUNT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        EV_RD,
        EV_WR,
        PS_RD,
        PS_DATA,
        CLEAR
    } hist_state_e;

    // Increments val and saturates at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/hist_rr_arb.sv
// Two-requester round-robin arbiter (event vs PS read); on a tie the last winner loses.
// The pointer comes out of reset favouring the event requester.
module hist_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_ev,
    input  logic req_ps,
    output logic gnt_ev,
    output logic gnt_ps
);

    logic prio_ev_q;
    logic prio_ev_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_ev_q <= 1'b1;
        end else begin
            prio_ev_q <= prio_ev_d;
        end
    end

    always_comb begin
        gnt_ev = 1'b0;
        gnt_ps = 1'b0;
        if (en) begin
            if (req_ev && (!req_ps || prio_ev_q)) begin
                gnt_ev = 1'b1;
            end else if (req_ps) begin
                gnt_ps = 1'b1;
            end
        end
        prio_ev_d = prio_ev_q;
        if (gnt_ev) begin
            prio_ev_d = 1'b0;
        end else if (gnt_ps) begin
            prio_ev_d = 1'b1;
        end
    end

endmodule

// File: rtl/histogram_bin_arbiter.sv
// Serialises event read-modify-write increments, PS bin reads and clear sweeps onto one bin RAM.
// Define HIST_DROP_COUNT_EN to add a saturating dropped_count of events discarded during a clear.
module histogram_bin_arbiter
    import hist_pkg::*;
#(
    parameter int BIN_COUNT   = DEF_BIN_COUNT,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int ADDR_WIDTH  = $clog2(BIN_COUNT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   event_valid,
    input  logic [ADDR_WIDTH-1:0]  event_bin,
    output logic                   event_ready,
    input  logic                   clear_start,
    output logic                   clear_busy,
    input  logic                   ps_rd_valid,
    input  logic [ADDR_WIDTH-1:0]  ps_rd_addr,
    output logic                   ps_rd_ready,
    output logic                   ps_rd_data_valid,
    output logic [COUNT_WIDTH-1:0] ps_rd_data,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [COUNT_WIDTH-1:0] mem_wdata,
    input  logic [COUNT_WIDTH-1:0] mem_rdata
`ifdef HIST_DROP_COUNT_EN
    ,
    output logic [15:0]            dropped_count
`endif
);

    hist_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clr_pend_q, clr_pend_d;
    logic                  clr_req;
    logic                  arb_en;
    logic                  gnt_ev;
    logic                  gnt_ps;

    // A pending or fresh clear pre-empts both requesters in IDLE.
    assign clr_req = clear_start || clr_pend_q;
    assign arb_en  = (state_q == IDLE) && !clr_req;

    hist_rr_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (arb_en),
        .req_ev (event_valid),
        .req_ps (ps_rd_valid),
        .gnt_ev (gnt_ev),
        .gnt_ps (gnt_ps)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            clr_addr_q <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            clr_addr_q <= clr_addr_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        clr_addr_d = clr_addr_q;
        clr_pend_d = clr_pend_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_pend_d = 1'b0;
                    clr_addr_d = '0;
                end else if (gnt_ev) begin
                    state_d = EV_RD;
                    addr_d  = event_bin;
                end else if (gnt_ps) begin
                    state_d = PS_RD;
                    addr_d  = ps_rd_addr;
                end
            end
            EV_RD:   state_d = EV_WR;
            EV_WR:   state_d = IDLE;
            PS_RD:   state_d = PS_DATA;
            PS_DATA: state_d = IDLE;
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == ADDR_WIDTH'(BIN_COUNT - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clears requested mid-operation wait for IDLE; a second clear during a sweep is dropped.
        if (clear_start && (state_q != IDLE) && (state_q != CLEAR)) begin
            clr_pend_d = 1'b1;
        end
    end

    always_comb begin
        event_ready      = gnt_ev;
        ps_rd_ready      = gnt_ps;
        ps_rd_data_valid = 1'b0;
        ps_rd_data       = '0;
        clear_busy       = 1'b0;
        mem_en           = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (state_q)
            EV_RD: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
            end
            EV_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = COUNT_WIDTH'(sat_inc(64'(mem_rdata), COUNT_WIDTH));
            end
            PS_RD: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
            end
            PS_DATA: begin
                ps_rd_data_valid = 1'b1;
                ps_rd_data       = mem_rdata;
            end
            CLEAR: begin
                event_ready = 1'b1;
                clear_busy  = 1'b1;
                mem_en      = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = clr_addr_q;
            end
            default: ;
        endcase
    end

`ifdef HIST_DROP_COUNT_EN
    logic [15:0] dropped_count_q, dropped_count_d;

    always_comb begin
        dropped_count_d = dropped_count_q;
        if ((state_q == CLEAR) && event_valid) begin
            dropped_count_d = 16'(sat_inc(64'(dropped_count_q), 16));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropped_count_q <= '0;
        end else begin
            dropped_count_q <= dropped_count_d;
        end
    end

    assign dropped_count = dropped_count_q;
`endif

endmodule

// File: tb/tb_histogram_bin_arbiter.sv
// Bench for histogram_bin_arbiter: behavioural 1-cycle-latency bin RAM, scoreboard queues
// for bin writes and PS read strobes, a vector table plus hand-written corner sequences.
module tb_histogram_bin_arbiter;

    localparam int AW = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          event_valid;
    logic [AW-1:0] event_bin;
    logic          event_ready;
    logic          clear_start;
    logic          clear_busy;
    logic          ps_rd_valid;
    logic [AW-1:0] ps_rd_addr;
    logic          ps_rd_ready;
    logic          ps_rd_data_valid;
    logic [CW-1:0] ps_rd_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_wdata;
    logic [CW-1:0] mem_rdata;
`ifdef HIST_DROP_COUNT_EN
    logic [15:0]   dropped_count;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
        int            cyc;
    } exp_t;

    typedef struct {
        bit            is_rd;
        logic [AW-1:0] addr;
        logic [CW-1:0] exp;
    } vec_t;

    exp_t wr_q[$];
    exp_t rd_q[$];
    vec_t vecs[12];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [CW-1:0] ram [256];
    logic          bd_zero;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [CW-1:0] bd_data;

    histogram_bin_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .event_valid      (event_valid),
        .event_bin        (event_bin),
        .event_ready      (event_ready),
        .clear_start      (clear_start),
        .clear_busy       (clear_busy),
        .ps_rd_valid      (ps_rd_valid),
        .ps_rd_addr       (ps_rd_addr),
        .ps_rd_ready      (ps_rd_ready),
        .ps_rd_data_valid (ps_rd_data_valid),
        .ps_rd_data       (ps_rd_data),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
`ifdef HIST_DROP_COUNT_EN
        ,
        .dropped_count    (dropped_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bd_zero) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
        end else if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [CW-1:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_event(input logic [AW-1:0] bin, input logic [CW-1:0] exp);
        int n;
        n = 0;
        event_valid = 1'b1;
        event_bin   = bin;
        #1;
        while (!event_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("event_handshake", 64'(event_ready), 64'd1);
        if (event_ready) wr_q.push_back('{bin, exp, cyc + 2});
        @(negedge clk);
        event_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [CW-1:0] exp);
        int n;
        n = 0;
        ps_rd_valid = 1'b1;
        ps_rd_addr  = a;
        #1;
        while (!ps_rd_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("read_handshake", 64'(ps_rd_ready), 64'd1);
        if (ps_rd_ready) rd_q.push_back('{a, exp, cyc + 2});
        @(negedge clk);
        ps_rd_valid = 1'b0;
    endtask

    // Both requesters held high until `want` grants; order collects 0=event, 1=PS, oldest in MSB.
    task automatic rr_run(input logic [AW-1:0] eb, input logic [AW-1:0] pa,
                          input logic [CW-1:0] ps_exp, input int want,
                          output logic [3:0] order, output int ng);
        int ne;
        ne    = 0;
        ng    = 0;
        order = '0;
        event_valid = 1'b1; event_bin  = eb;
        ps_rd_valid = 1'b1; ps_rd_addr = pa;
        for (int k = 0; k < 40 && ng < want; k++) begin
            #1;
            if (event_ready) begin
                order = {order[2:0], 1'b0};
                wr_q.push_back('{eb, CW'(ne + 1), cyc + 2});
                ne++;
                ng++;
            end else if (ps_rd_ready) begin
                order = {order[2:0], 1'b1};
                rd_q.push_back('{pa, ps_exp, cyc + 2});
                ng++;
            end
            @(negedge clk);
        end
        event_valid = 1'b0;
        ps_rd_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!reset) begin
                if (mem_en && mem_we && !clear_busy) begin
                    if (wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none required", mem_addr, mem_wdata);
                    end else begin
                        e = wr_q.pop_front();
                        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                        chk("wr_data", 64'(mem_wdata), 64'(e.data));
                        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (ps_rd_data_valid) begin
                    if (rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_strobe: data 0x%0h, none required", ps_rd_data);
                    end else begin
                        e = rd_q.pop_front();
                        chk("rd_data", 64'(ps_rd_data), 64'(e.data));
                        chk("rd_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] order;
        int ng, n, bad_wr, bad_rdy;

        reset = 1'b1;
        event_valid = 1'b0; event_bin  = '0;
        clear_start = 1'b0;
        ps_rd_valid = 1'b0; ps_rd_addr = '0;
        bd_zero = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        vecs[0]  = '{1'b0, 8'd9,   32'hFFFF_FFFF};
        vecs[1]  = '{1'b0, 8'd9,   32'hFFFF_FFFF};
        vecs[2]  = '{1'b0, 8'd10,  32'hFFFF_FFFF};
        vecs[3]  = '{1'b1, 8'd10,  32'hFFFF_FFFF};
        vecs[4]  = '{1'b0, 8'd200, 32'd101};
        vecs[5]  = '{1'b0, 8'd200, 32'd102};
        vecs[6]  = '{1'b0, 8'd200, 32'd103};
        vecs[7]  = '{1'b1, 8'd200, 32'd103};
        vecs[8]  = '{1'b1, 8'd5,   32'd8};
        vecs[9]  = '{1'b0, 8'd0,   32'd1};
        vecs[10] = '{1'b1, 8'd0,   32'd1};
        vecs[11] = '{1'b1, 8'd255, 32'd0};

        @(negedge clk);
        bd_zero = 1'b0;
        #1;
        chk("rst_event_ready", 64'(event_ready), 64'd0);
        chk("rst_ps_rd_ready", 64'(ps_rd_ready), 64'd0);
        chk("rst_clear_busy", 64'(clear_busy), 64'd0);
        chk("rst_ps_strobe", 64'({ps_rd_data_valid, ps_rd_data}), 64'd0);
        chk("rst_mem", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
`ifdef HIST_DROP_COUNT_EN
        chk("rst_dropped", 64'(dropped_count), 64'd0);
`endif
        poke(8'd5, 32'd7);
        poke(8'd9, 32'hFFFF_FFFE);
        poke(8'd10, 32'hFFFF_FFFF);
        poke(8'd200, 32'd100);
        reset = 1'b0;
        @(negedge clk);

        // Single event on bin 5 holding 7, cycle by cycle.
        event_valid = 1'b1; event_bin = 8'd5;
        #1;
        chk("single_ready", 64'(event_ready), 64'd1);
        wr_q.push_back('{8'd5, 32'd8, cyc + 2});
        @(negedge clk);
        event_valid = 1'b0;
        #1;
        chk("single_rd_cycle", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b0, 8'd5}));
        @(negedge clk); #1;
        chk("single_wr_cycle", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b1, 8'd5}));
        chk("single_wdata", 64'(mem_wdata), 64'd8);
        @(negedge clk);
        event_valid = 1'b1; event_bin = 8'd5;
        #1;
        chk("single_ready_again", 64'(event_ready), 64'd1);
        event_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_rd) do_read(vecs[i].addr, vecs[i].exp);
            else               do_event(vecs[i].addr, vecs[i].exp);
        end

        // Continuous contention after a PS grant: E,P,E,P.
        rr_run(8'd6, 8'd5, 32'd8, 4, order, ng);
        chk("rr_grants", 64'(ng), 64'd4);
        chk("rr_order", 64'(order), 64'b0101);
        repeat (3) @(negedge clk);

        // Clear requested while an increment is in its write cycle.
        event_valid = 1'b1; event_bin = 8'd7;
        #1;
        chk("clr_ev_ready", 64'(event_ready), 64'd1);
        wr_q.push_back('{8'd7, 32'd1, cyc + 2});
        @(negedge clk);
        event_valid = 1'b0;
        @(negedge clk);
        clear_start = 1'b1;
        #1;
        chk("clr_in_ev_wr", 64'({mem_we, clear_busy}), 64'b10);
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        chk("clr_pending_idle", 64'(clear_busy), 64'd0);
        n = 0;
        while (!clear_busy && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk("clr_started", 64'(clear_busy), 64'd1);
        chk("clr_start_delay", 64'(n), 64'd1);
        bad_wr = 0; bad_rdy = 0;
        ps_rd_valid = 1'b1; ps_rd_addr = 8'd5;
        for (int i = 0; i < 256; i++) begin
            if (i == 20)  event_valid = 1'b1;
            if (i == 30)  event_valid = 1'b0;
            if (i == 50)  clear_start = 1'b1;
            if (i == 51)  clear_start = 1'b0;
            if (i == 255) ps_rd_valid = 1'b0;
            #1;
            if (!(clear_busy && mem_en && mem_we && mem_addr == 8'(i) && mem_wdata == '0)) bad_wr++;
            if (!event_ready || ps_rd_ready) bad_rdy++;
            @(negedge clk); #1;
        end
        chk("clr_sweep_writes", 64'(bad_wr), 64'd0);
        chk("clr_ready_levels", 64'(bad_rdy), 64'd0);
        chk("clr_busy_len", 64'(clear_busy), 64'd0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (clear_busy || mem_en) n++;
        end
        chk("clr_no_restart", 64'(n), 64'd0);
`ifdef HIST_DROP_COUNT_EN
        chk("clr_dropped", 64'(dropped_count), 64'd10);
`endif
        do_read(8'd5, 32'd0);
        do_read(8'd7, 32'd0);
        do_read(8'd200, 32'd0);
        do_read(8'd255, 32'd0);
        do_event(8'd3, 32'd1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a clear sweep.
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        n = 0;
        while (!(clear_busy && mem_addr == 8'd100) && n < 300) begin
            @(negedge clk); #1; n++;
        end
        chk("rst_mid_clr_addr", 64'({clear_busy, mem_addr}), 64'({1'b1, 8'd100}));
        reset = 1'b1;
        #1;
        chk("rst_mid_clr_busy", 64'(clear_busy), 64'd0);
        chk("rst_mid_clr_mem", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
        chk("rst_mid_clr_strobes", 64'({event_ready, ps_rd_ready, ps_rd_data_valid}), 64'd0);
`ifdef HIST_DROP_COUNT_EN
        chk("rst_mid_clr_dropped", 64'(dropped_count), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_no_pending", 64'({clear_busy, mem_en}), 64'd0);
        @(negedge clk);

        // Pointer favours the event again after reset, though the last grant was an event.
        rr_run(8'd3, 8'd3, 32'd1, 2, order, ng);
        chk("rst_rr_grants", 64'(ng), 64'd2);
        chk("rst_rr_order", 64'(order), 64'b0001);
        repeat (4) @(negedge clk);

        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
